// File: rtl/banco_cuentas.sv
// Bank host: per-account PIN/balance/lock store answering ATM account queries.
// Latency: respuesta_stb/cuenta_invalida LATENCIA cycles after the query cycle; escritura_ok 1 cycle after balance_stb.
// Backpressure: none; queries, write-backs and program writes outside their accepting states are dropped.
// Optional feature macro: CUENTA_TRANS_EN adds trans_total, a saturating count of committed write-backs.
module banco_cuentas #(
    parameter int          NUM_CUENTAS   = 8,
    parameter int          ID_W          = 3,
    parameter int          LATENCIA      = 4,
    parameter logic [15:0] PIN_RESET     = 16'h1234,
    parameter logic [63:0] BALANCE_RESET = 64'd1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            consulta_stb,
    input  logic [ID_W-1:0] id_cuenta,
    output logic [15:0]     pin_correcto,
    output logic [63:0]     balance_inicial,
    output logic            respuesta_stb,
    output logic            cuenta_invalida,
    input  logic [63:0]     balance_actualizado,
    input  logic            balance_stb,
    input  logic            bloqueo,
    output logic            escritura_ok,
    output logic            ocupado,
    input  logic            prog_we,
    input  logic [ID_W-1:0] prog_id,
    input  logic [15:0]     prog_pin,
    input  logic [63:0]     prog_balance
`ifdef CUENTA_TRANS_EN
    ,
    output logic [15:0]     trans_total
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ESPERA = 2'd1,
        SESION = 2'd2
    } estado_t;

    localparam logic [3:0] LAT_INI = 4'(LATENCIA - 1);

    estado_t         estado_q, estado_d;
    logic [3:0]      lat_cnt_q, lat_cnt_d;
    logic [ID_W-1:0] id_activo_q, id_activo_d;
    logic [15:0]     pin_mem_q [NUM_CUENTAS];
    logic [15:0]     pin_mem_d [NUM_CUENTAS];
    logic [63:0]     bal_mem_q [NUM_CUENTAS];
    logic [63:0]     bal_mem_d [NUM_CUENTAS];
    logic            lock_q    [NUM_CUENTAS];
    logic            lock_d    [NUM_CUENTAS];
    logic [15:0]     pin_ses_q, pin_ses_d;
    logic [63:0]     bal_ses_q, bal_ses_d;
    logic            escritura_ok_q, escritura_ok_d;
    logic            bloqueo_q;
    logic            bloqueo_flanco;

    logic            act_valida;
    logic            act_lock;
    logic [15:0]     act_pin;
    logic [63:0]     act_bal;

    // Only a low-to-high transition of the level-type lock request counts.
    assign bloqueo_flanco = bloqueo & ~bloqueo_q;

    // Look up the latched account; ids with no matching entry stay invalid.
    always_comb begin
        act_valida = 1'b0;
        act_lock   = 1'b0;
        act_pin    = '0;
        act_bal    = '0;
        for (int i = 0; i < NUM_CUENTAS; i++) begin
            if (ID_W'(i) == id_activo_q) begin
                act_valida = 1'b1;
                act_lock   = lock_q[i];
                act_pin    = pin_mem_q[i];
                act_bal    = bal_mem_q[i];
            end
        end
    end

    // Next-state, account-store updates and response strobes.
    always_comb begin
        estado_d        = estado_q;
        lat_cnt_d       = lat_cnt_q;
        id_activo_d     = id_activo_q;
        pin_mem_d       = pin_mem_q;
        bal_mem_d       = bal_mem_q;
        lock_d          = lock_q;
        pin_ses_d       = pin_ses_q;
        bal_ses_d       = bal_ses_q;
        escritura_ok_d  = 1'b0;
        respuesta_stb   = 1'b0;
        cuenta_invalida = 1'b0;

        case (estado_q)
            IDLE: begin
                // Program write is taken in the same cycle as a query; the
                // lookup happens later, so the query sees the new contents.
                if (prog_we) begin
                    for (int i = 0; i < NUM_CUENTAS; i++) begin
                        if (ID_W'(i) == prog_id) begin
                            pin_mem_d[i] = prog_pin;
                            bal_mem_d[i] = prog_balance;
                            lock_d[i]    = 1'b0;
                        end
                    end
                end
                if (consulta_stb) begin
                    id_activo_d = id_cuenta;
                    lat_cnt_d   = LAT_INI;
                    estado_d    = ESPERA;
                end
            end

            ESPERA: begin
                if (lat_cnt_q == 4'd0) begin
                    if (act_valida && !act_lock) begin
                        respuesta_stb = 1'b1;
                        pin_ses_d     = act_pin;
                        bal_ses_d     = act_bal;
                        estado_d      = SESION;
                    end else begin
                        cuenta_invalida = 1'b1;
                        estado_d        = IDLE;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end

            SESION: begin
                // Lock beats write-back beats a new query when they coincide.
                if (bloqueo_flanco) begin
                    for (int i = 0; i < NUM_CUENTAS; i++) begin
                        if (ID_W'(i) == id_activo_q) begin
                            lock_d[i] = 1'b1;
                        end
                    end
                    pin_ses_d = '0;
                    bal_ses_d = '0;
                    estado_d  = IDLE;
                end else if (balance_stb) begin
                    for (int i = 0; i < NUM_CUENTAS; i++) begin
                        if (ID_W'(i) == id_activo_q) begin
                            bal_mem_d[i] = balance_actualizado;
                        end
                    end
                    escritura_ok_d = 1'b1;
                    pin_ses_d      = '0;
                    bal_ses_d      = '0;
                    estado_d       = IDLE;
                end else if (consulta_stb) begin
                    // Session abandoned without write-back; new query starts.
                    id_activo_d = id_cuenta;
                    lat_cnt_d   = LAT_INI;
                    pin_ses_d   = '0;
                    bal_ses_d   = '0;
                    estado_d    = ESPERA;
                end
            end

            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // Response data is live in the response cycle, then held by the session registers.
    always_comb begin
        pin_correcto    = respuesta_stb ? act_pin : pin_ses_q;
        balance_inicial = respuesta_stb ? act_bal : bal_ses_q;
    end

    assign escritura_ok = escritura_ok_q;
    assign ocupado      = (estado_q != IDLE);

    // State, session and account-store registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q       <= IDLE;
            lat_cnt_q      <= '0;
            id_activo_q    <= '0;
            pin_ses_q      <= '0;
            bal_ses_q      <= '0;
            escritura_ok_q <= 1'b0;
            bloqueo_q      <= 1'b0;
            for (int i = 0; i < NUM_CUENTAS; i++) begin
                pin_mem_q[i] <= PIN_RESET;
                bal_mem_q[i] <= BALANCE_RESET;
                lock_q[i]    <= 1'b0;
            end
        end else begin
            estado_q       <= estado_d;
            lat_cnt_q      <= lat_cnt_d;
            id_activo_q    <= id_activo_d;
            pin_ses_q      <= pin_ses_d;
            bal_ses_q      <= bal_ses_d;
            escritura_ok_q <= escritura_ok_d;
            bloqueo_q      <= bloqueo;
            pin_mem_q      <= pin_mem_d;
            bal_mem_q      <= bal_mem_d;
            lock_q         <= lock_d;
        end
    end

`ifdef CUENTA_TRANS_EN
    logic [15:0] trans_total_q, trans_total_d;

    // Count committed write-backs, sticking at all-ones.
    always_comb begin
        trans_total_d = trans_total_q;
        if (escritura_ok_q && (trans_total_q != 16'hFFFF)) begin
            trans_total_d = trans_total_q + 16'd1;
        end
    end

    // Write-back counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            trans_total_q <= '0;
        end else begin
            trans_total_q <= trans_total_d;
        end
    end

    assign trans_total = trans_total_q;
`endif

endmodule

// File: tb/tb_banco_cuentas.sv
// Self-checking bench for banco_cuentas: directed transaction table, hand-written
// corner sequences, a 6-account instance for range checks, and random traffic.
// Expected values come from the table constants or a per-account array model.
module tb_banco_cuentas;

    localparam int LAT = 4;
    localparam int NC  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        consulta_stb = 1'b0;
    logic [2:0]  id_cuenta = '0;
    logic [63:0] balance_actualizado = '0;
    logic        balance_stb = 1'b0;
    logic        bloqueo = 1'b0;
    logic        prog_we = 1'b0;
    logic [2:0]  prog_id = '0;
    logic [15:0] prog_pin = '0;
    logic [63:0] prog_balance = '0;

    logic [15:0] pin_correcto, pin6;
    logic [63:0] balance_inicial, bal6;
    logic        respuesta_stb, cuenta_invalida, escritura_ok, ocupado;
    logic        resp6, inv6, ok6, ocu6;
`ifdef CUENTA_TRANS_EN
    logic [15:0] trans_total, trans6;
`endif

    always #5 clk = ~clk;

    banco_cuentas dut (
        .clk(clk), .reset(reset), .consulta_stb(consulta_stb), .id_cuenta(id_cuenta),
        .pin_correcto(pin_correcto), .balance_inicial(balance_inicial),
        .respuesta_stb(respuesta_stb), .cuenta_invalida(cuenta_invalida),
        .balance_actualizado(balance_actualizado), .balance_stb(balance_stb),
        .bloqueo(bloqueo), .escritura_ok(escritura_ok), .ocupado(ocupado),
        .prog_we(prog_we), .prog_id(prog_id), .prog_pin(prog_pin), .prog_balance(prog_balance)
`ifdef CUENTA_TRANS_EN
        , .trans_total(trans_total)
`endif
    );

    banco_cuentas #(.NUM_CUENTAS(6)) dut6 (
        .clk(clk), .reset(reset), .consulta_stb(consulta_stb), .id_cuenta(id_cuenta),
        .pin_correcto(pin6), .balance_inicial(bal6),
        .respuesta_stb(resp6), .cuenta_invalida(inv6),
        .balance_actualizado(balance_actualizado), .balance_stb(balance_stb),
        .bloqueo(bloqueo), .escritura_ok(ok6), .ocupado(ocu6),
        .prog_we(prog_we), .prog_id(prog_id), .prog_pin(prog_pin), .prog_balance(prog_balance)
`ifdef CUENTA_TRANS_EN
        , .trans_total(trans6)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Account model
    logic [15:0] m_pin  [NC];
    logic [63:0] m_bal  [NC];
    bit          m_lock [NC];
    int          m_trans;

    typedef enum {OP_WR, OP_LK, OP_AB, OP_PRG} op_t;
    typedef struct {
        op_t         op;
        int          id;
        logic [15:0] pin;      // PRG: pin to program
        logic [63:0] val;      // PRG: balance; WR: write-back value
        bit          exp_ok;   // query: response expected; PRG: write takes effect
        logic [15:0] exp_pin;
        logic [63:0] exp_bal;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < NC; i++) begin
            m_pin[i]  = 16'h1234;
            m_bal[i]  = 64'd1000;
            m_lock[i] = 1'b0;
        end
        m_trans = 0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        consulta_stb = 1'b0; balance_stb = 1'b0; bloqueo = 1'b0; prog_we = 1'b0;
        tick;
        tick;
        chk("rst_resp", respuesta_stb, 0);
        chk("rst_inv", cuenta_invalida, 0);
        chk("rst_pin", pin_correcto, 0);
        chk("rst_bal", balance_inicial, 0);
        chk("rst_ok", escritura_ok, 0);
        chk("rst_busy", ocupado, 0);
`ifdef CUENTA_TRANS_EN
        chk("rst_trans", trans_total, 0);
`endif
        reset = 1'b0;
        model_reset();
    endtask

    // Issue a query (from IDLE or SESION) and check the full response window.
    // Returns one cycle after the response, i.e. first SESION cycle or IDLE.
    task automatic query(input int id, input bit eok, input logic [15:0] epin, input logic [63:0] ebal);
        consulta_stb = 1'b1;
        id_cuenta = 3'(id);
        tick;
        consulta_stb = 1'b0;
        prog_we = 1'b0;
        for (int k = 1; k < LAT; k++) begin
            chk("wait_resp", respuesta_stb, 0);
            chk("wait_inv", cuenta_invalida, 0);
            chk("wait_pin", pin_correcto, 0);
            chk("wait_busy", ocupado, 1);
            tick;
        end
        chk("resp", respuesta_stb, eok);
        chk("inv", cuenta_invalida, !eok);
        chk("resp_pin", pin_correcto, eok ? epin : 16'h0);
        chk("resp_bal", balance_inicial, eok ? ebal : 64'h0);
        chk("resp_busy", ocupado, 1);
        tick;
        chk("resp_pulse", respuesta_stb, 0);
        chk("inv_pulse", cuenta_invalida, 0);
        if (eok) begin
            chk("hold_pin", pin_correcto, epin);
            chk("hold_bal", balance_inicial, ebal);
            chk("sess_busy", ocupado, 1);
        end else begin
            chk("inv_idle", ocupado, 0);
        end
    endtask

    task automatic query_model(input int id, output bit ok);
        ok = !m_lock[id];
        query(id, ok, m_pin[id], m_bal[id]);
    endtask

    task automatic wb(input int id, input logic [63:0] v);
        balance_stb = 1'b1;
        balance_actualizado = v;
        tick;
        balance_stb = 1'b0;
        chk("wb_ok", escritura_ok, 1);
        chk("wb_idle", ocupado, 0);
        chk("wb_pin_clr", pin_correcto, 0);
        chk("wb_bal_clr", balance_inicial, 0);
        m_bal[id] = v;
        if (m_trans < 16'hFFFF) m_trans++;
        tick;
        chk("wb_ok_pulse", escritura_ok, 0);
`ifdef CUENTA_TRANS_EN
        chk("wb_trans", trans_total, 64'(m_trans));
`endif
    endtask

    task automatic lock(input int id);
        bloqueo = 1'b1;
        tick;
        chk("lk_no_ok", escritura_ok, 0);
        chk("lk_idle", ocupado, 0);
        chk("lk_pin_clr", pin_correcto, 0);
        m_lock[id] = 1'b1;
        bloqueo = 1'b0;
        tick;
    endtask

    task automatic prog(input int id, input logic [15:0] p, input logic [63:0] v, input bit applies);
        prog_we = 1'b1;
        prog_id = 3'(id);
        prog_pin = p;
        prog_balance = v;
        tick;
        prog_we = 1'b0;
        if (applies) begin
            m_pin[id] = p;
            m_bal[id] = v;
            m_lock[id] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int id;
        int r;
        logic [15:0] tr_before;

        tbl[0]  = '{OP_WR,  2, 16'h0,    64'd750,     1'b1, 16'h1234, 64'd1000};
        tbl[1]  = '{OP_AB,  2, 16'h0,    64'd0,       1'b1, 16'h1234, 64'd750};
        tbl[2]  = '{OP_LK,  5, 16'h0,    64'd0,       1'b1, 16'h1234, 64'd1000};
        tbl[3]  = '{OP_AB,  5, 16'h0,    64'd0,       1'b0, 16'h0,    64'd0};
        tbl[4]  = '{OP_PRG, 5, 16'h0420, 64'd50,      1'b1, 16'h0,    64'd0};
        tbl[5]  = '{OP_AB,  5, 16'h0,    64'd0,       1'b1, 16'h0420, 64'd50};
        tbl[6]  = '{OP_AB,  1, 16'h0,    64'd0,       1'b1, 16'h1234, 64'd1000};
        tbl[7]  = '{OP_AB,  3, 16'h0,    64'd0,       1'b1, 16'h1234, 64'd1000};
        tbl[8]  = '{OP_WR,  1, 16'h0,    64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 16'h1234, 64'd1000};
        tbl[9]  = '{OP_WR,  1, 16'h0,    64'd0,       1'b1, 16'h1234, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[10] = '{OP_PRG, 7, 16'hBEEF, 64'd7,       1'b1, 16'h0,    64'd0};
        tbl[11] = '{OP_AB,  7, 16'h0,    64'd0,       1'b1, 16'hBEEF, 64'd7};
        tbl[12] = '{OP_PRG, 0, 16'hAAAA, 64'd9,       1'b0, 16'h0,    64'd0};
        tbl[13] = '{OP_AB,  0, 16'h0,    64'd0,       1'b1, 16'h1234, 64'd1000};
        tbl[14] = '{OP_WR,  0, 16'h0,    64'd5,       1'b1, 16'h1234, 64'd1000};
        tbl[15] = '{OP_PRG, 0, 16'h5555, 64'd6,       1'b1, 16'h0,    64'd0};
        tbl[16] = '{OP_WR,  0, 16'h0,    64'd1,       1'b1, 16'h5555, 64'd6};

        do_reset();

        // Directed transaction table
        foreach (tbl[i]) begin
            case (tbl[i].op)
                OP_PRG: prog(tbl[i].id, tbl[i].pin, tbl[i].val, tbl[i].exp_ok);
                OP_WR: begin
                    query(tbl[i].id, tbl[i].exp_ok, tbl[i].exp_pin, tbl[i].exp_bal);
                    wb(tbl[i].id, tbl[i].val);
                end
                OP_LK: begin
                    query(tbl[i].id, tbl[i].exp_ok, tbl[i].exp_pin, tbl[i].exp_bal);
                    lock(tbl[i].id);
                end
                default: query(tbl[i].id, tbl[i].exp_ok, tbl[i].exp_pin, tbl[i].exp_bal);
            endcase
        end

        // Lock edge and write-back in the same cycle: lock wins, nothing committed
        query(3, 1'b1, 16'h1234, 64'd1000);
`ifdef CUENTA_TRANS_EN
        tr_before = trans_total;
`else
        tr_before = 16'(m_trans);
`endif
        bloqueo = 1'b1;
        balance_stb = 1'b1;
        balance_actualizado = 64'd0;
        tick;
        balance_stb = 1'b0;
        bloqueo = 1'b0;
        chk("race_idle", ocupado, 0);
        tick;
        chk("race_no_ok", escritura_ok, 0);
`ifdef CUENTA_TRANS_EN
        chk("race_trans", trans_total, 64'(tr_before));
`endif
        m_lock[3] = 1'b1;
        query(3, 1'b0, 16'h0, 64'h0);

        // Inputs during ESPERA are ignored
        consulta_stb = 1'b1; id_cuenta = 3'd4;
        tick;
        consulta_stb = 1'b1; id_cuenta = 3'd6;
        prog_we = 1'b1; prog_id = 3'd4; prog_pin = 16'h9999; prog_balance = 64'd9;
        balance_stb = 1'b1; balance_actualizado = 64'd77; bloqueo = 1'b1;
        tick;
        consulta_stb = 1'b0; prog_we = 1'b0; balance_stb = 1'b0; bloqueo = 1'b0;
        chk("esp_no_ok", escritura_ok, 0);
        tick;
        chk("esp_resp_early", respuesta_stb, 0);
        tick;
        chk("esp_resp", respuesta_stb, 1);
        chk("esp_pin", pin_correcto, 16'h1234);
        chk("esp_bal", balance_inicial, 64'd1000);
        tick;
        wb(4, 64'd44);

        // Program write coinciding with a query, and bloqueo held high (no edge)
        m_pin[6] = 16'h6666; m_bal[6] = 64'd66;
        prog_we = 1'b1; prog_id = 3'd6; prog_pin = 16'h6666; prog_balance = 64'd66;
        bloqueo = 1'b1;
        query(6, 1'b1, 16'h6666, 64'd66);
        tick;
        chk("lvl_busy", ocupado, 1);
        chk("lvl_hold_pin", pin_correcto, 16'h6666);
        bloqueo = 1'b0;
        tick;
        chk("lvl_busy2", ocupado, 1);
        bloqueo = 1'b1;
        tick;
        chk("edge_idle", ocupado, 0);
        m_lock[6] = 1'b1;
        bloqueo = 1'b0;
        tick;
        query_model(6, ok);
        chk("locked6", ok, 0);

        // Six-account instance: range boundary
        do_reset();
        consulta_stb = 1'b1; id_cuenta = 3'd7;
        tick;
        consulta_stb = 1'b0;
        repeat (LAT - 1) tick;
        chk("d6_inv_7", inv6, 1);
        chk("d6_resp_7", resp6, 0);
        chk("d6_pin_7", pin6, 0);
        chk("d6_bal_7", bal6, 0);
        chk("d8_resp_7", respuesta_stb, 1);
        tick;
        chk("d6_idle", ocu6, 0);
        prog(6, 16'h0606, 64'd606, 1'b0);
        consulta_stb = 1'b1; id_cuenta = 3'd5;
        tick;
        consulta_stb = 1'b0;
        repeat (LAT - 1) tick;
        chk("d6_resp_5", resp6, 1);
        chk("d6_pin_5", pin6, 16'h1234);
        chk("d6_bal_5", bal6, 64'd1000);
        chk("d8_resp_5", respuesta_stb, 1);
        tick;
        consulta_stb = 1'b1; id_cuenta = 3'd6;
        tick;
        consulta_stb = 1'b0;
        repeat (LAT - 1) tick;
        chk("d6_inv_6", inv6, 1);
        chk("d8_pin_6", pin_correcto, 16'h1234);

        // Random traffic against the model
        do_reset();
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                id = $urandom_range(0, NC - 1);
                prog(id, 16'($urandom), {$urandom, $urandom}, 1'b1);
            end else begin
                id = $urandom_range(0, NC - 1);
                query_model(id, ok);
                while (ok && ($urandom_range(0, 3) == 0)) begin
                    id = $urandom_range(0, NC - 1);
                    query_model(id, ok);
                end
                if (ok) begin
                    if ($urandom_range(0, 4) == 0) lock(id);
                    else wb(id, {$urandom, $urandom});
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
